percep_mem_loader: RTL and testbench
====================================

Name: percep_mem_loader

Overview:
- Front-end writer that fills the perceptron memories before inference starts.
- Accepts a valid/ready word stream, with words in datamem.txt order:
  - ATTR weight words (w0..w4) first;
  - then INFER_NUM*ATTR ydx words, where yd sits in bit 16 of each %ATTR==0 address and x sits in bits [15:0].
- Drives the write ports of the weight and ydx memories, then raises load_done, which the top ties to the inference FSM's infer_ena.

Parameters:
- MEM_WIDTH_YDX, 17, ydx word width and stream word width
- MEM_ADDR_YDX, 7, ydx memory address width
- MEM_ADDR_WGHT, 3, weight memory address width
- INFER_NUM, 20, number of inference datasets
- ATTR, 5, attributes per dataset and number of weights
- FP_WIDTH, 16, fp data width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- load_start  in  1  one-cycle pulse that begins or restarts a load
- s_data  in  MEM_WIDTH_YDX  stream word
- s_valid  in  1  s_data valid
- s_ready  out  1  loader can accept a word
- mem_cs_ydx  out  1  ydx memory chip select
- mem_we_ydx  out  1  ydx memory write enable
- mem_oe_ydx  out  1  ydx memory read enable (always 0)
- d_addr_ydx  out  MEM_ADDR_YDX  ydx memory address
- mem_cs_wght  out  1  weight memory chip select
- mem_we_wght  out  1  weight memory write enable
- mem_oe_wght  out  1  weight memory read enable (always 0)
- d_addr_wght  out  MEM_ADDR_WGHT  weight memory address
- d_mem_in  out  MEM_WIDTH_YDX  write data to both memories; the weight memory takes [FP_WIDTH-1:0]
- load_done  out  1  level; all words written
- load_err  out  1  level; error detected (checksum feature only)

Behaviour:
- Reset: the single clock is clk; reset is synchronous and active-high on rst.
  - Reset takes priority over every other input.
  - All outputs go to 0 and the state goes to IDLE, including when a load is in progress (a partial load is abandoned).
- States: IDLE, LD_WGHT, LD_YDX, DONE.
  - IDLE -> LD_WGHT on load_start.
  - LD_WGHT -> LD_YDX after the ATTR-th accepted word.
  - LD_YDX -> DONE after the (INFER_NUM*ATTR)-th accepted word.
  - DONE -> LD_WGHT on load_start.
  - load_start in LD_WGHT or LD_YDX restarts at LD_WGHT. The counters clear, load_done and load_err clear, and no word is accepted in that cycle.
- Handshake:
  - s_ready = 1 only in LD_WGHT and LD_YDX, and 0 in the cycle load_start is sampled.
  - A word is accepted when s_valid & s_ready are high on a rising edge.
  - s_valid may drop at any time; there is no timeout.
- Write timing (1-cycle latency): for a word accepted at edge t, all strobes, d_addr_* and d_mem_in are registered and valid during cycle t+1.
  - Weight write: mem_cs_wght = mem_we_wght = 1.
  - ydx write: mem_cs_ydx = mem_we_ydx = 1.
  - Strobes are 0 in cycles with no acceptance.
- Address counters:
  - wght_cnt runs 0..ATTR-1.
  - ydx_cnt runs 0..INFER_NUM*ATTR-1 and must fit MEM_ADDR_YDX bits (100 < 128).
  - Counters do not wrap. At the terminal count the state advances and s_ready drops in the same edge, so a word presented after the last one stays unaccepted.
- load_done is set in the cycle after the final write is issued, so it follows the last write strobe. It holds until rst or load_start.
- Data passes unmodified. The weight memory uses the low FP_WIDTH bits, and bit 16 of weight words is ignored.

Optional Feature:
- Macro: LOAD_CSUM_EN.
- With LOAD_CSUM_EN:
  - One extra trailer word follows the ydx words and is accepted in a state CHK, entered from LD_YDX.
  - Checksum = modulo-2^17 sum of all ATTR + INFER_NUM*ATTR data words.
  - The trailer is not written to memory.
  - On mismatch, load_err = 1 and load_done stays 0. On match, load_done = 1. Both are set the cycle after trailer acceptance.
- Without LOAD_CSUM_EN: there is no CHK state and load_err is tied to 0.

Decomposition:
- Package percep_pkg holds:
  - the width constants;
  - YDX_WORDS = INFER_NUM*ATTR;
  - the state enum: IDLE, LD_WGHT, LD_YDX, CHK, DONE.
- Sub-module percep_ld_csum is the 17-bit accumulator with clear, enable and compare. It is instantiated only under LOAD_CSUM_EN.

Test Plan:
- Reset then load_start, 105 words with s_valid held high:
  - weight writes at addr 0..4 with the data matching;
  - ydx writes at addr 0..99;
  - load_done rises 1 cycle after the last write;
  - s_ready = 0 afterwards.
- Random s_valid gaps of 0..3 cycles: same memory image; no write strobe in idle cycles.
- rst asserted after 50 words, then load_start and 105 words: counters restart at 0 and the final image is correct.
- load_start at word 30: the next accepted word goes to weight addr 0 and load_done stays 0 until 105 new words are accepted.
- A word held valid after word 105: it is never accepted and no 106th write occurs.
- LOAD_CSUM_EN:
  - correct trailer gives load_done = 1, load_err = 0;
  - trailer+1 gives load_err = 1, load_done = 0.

Source files
------------

// File: rtl/percep_pkg.sv
// Shared constants and state encoding for the perceptron memory loader.
package percep_pkg;

    localparam int MEM_WIDTH_YDX = 17;
    localparam int MEM_ADDR_YDX  = 7;
    localparam int MEM_ADDR_WGHT = 3;
    localparam int INFER_NUM     = 20;
    localparam int ATTR          = 5;
    localparam int FP_WIDTH      = 16;
    localparam int YDX_WORDS     = INFER_NUM * ATTR;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_WGHT = 3'd1,
        LD_YDX  = 3'd2,
        CHK     = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/percep_ld_csum.sv
// Modulo-2^17 running sum of loaded data words, compared against the trailer word.
// Only instantiated in builds with LOAD_CSUM_EN defined.
module percep_ld_csum
    import percep_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic [MEM_WIDTH_YDX-1:0] din_i,
    input  logic [MEM_WIDTH_YDX-1:0] cmp_i,
    output logic                     match_o
);

    logic [MEM_WIDTH_YDX-1:0] sum_q, sum_d;

    // Next sum: clear wins over accumulate; the add wraps naturally at 17 bits.
    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = '0;
        end else if (en_i) begin
            sum_d = sum_q + din_i;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign match_o = (sum_q == cmp_i);

endmodule

// File: rtl/percep_mem_loader.sv
// Stream-to-memory loader: writes ATTR weight words then YDX_WORDS ydx words,
// then raises load_done. Optional trailer checksum under LOAD_CSUM_EN.
//
// state   | meaning
// IDLE    | waiting for the first load_start
// LD_WGHT | accepting weight words w0..w(ATTR-1)
// LD_YDX  | accepting ydx words 0..YDX_WORDS-1
// CHK     | accepting the checksum trailer (LOAD_CSUM_EN only)
// DONE    | image complete, waiting for load_start
module percep_mem_loader
    import percep_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_start,
    input  logic [MEM_WIDTH_YDX-1:0] s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic                     mem_cs_ydx,
    output logic                     mem_we_ydx,
    output logic                     mem_oe_ydx,
    output logic [MEM_ADDR_YDX-1:0]  d_addr_ydx,
    output logic                     mem_cs_wght,
    output logic                     mem_we_wght,
    output logic                     mem_oe_wght,
    output logic [MEM_ADDR_WGHT-1:0] d_addr_wght,
    output logic [MEM_WIDTH_YDX-1:0] d_mem_in,
    output logic                     load_done,
    output logic                     load_err
);

    localparam logic [MEM_ADDR_WGHT-1:0] WGHT_LAST = MEM_ADDR_WGHT'(ATTR - 1);
    localparam logic [MEM_ADDR_YDX-1:0]  YDX_LAST  = MEM_ADDR_YDX'(YDX_WORDS - 1);

    state_t                   state_q, state_d;
    logic [MEM_ADDR_WGHT-1:0] wght_cnt_q, wght_cnt_d;
    logic [MEM_ADDR_YDX-1:0]  ydx_cnt_q, ydx_cnt_d;
    logic                     wr_wght_q, wr_wght_d;
    logic                     wr_ydx_q, wr_ydx_d;
    logic [MEM_ADDR_WGHT-1:0] addr_wght_q, addr_wght_d;
    logic [MEM_ADDR_YDX-1:0]  addr_ydx_q, addr_ydx_d;
    logic [MEM_WIDTH_YDX-1:0] data_q, data_d;
    logic                     done_q, done_d;
    logic                     busy;
    logic                     accept;

    assign busy    = (state_q == LD_WGHT) || (state_q == LD_YDX) || (state_q == CHK);
    // The load_start cycle never accepts a word, so a restart begins cleanly.
    assign s_ready = busy && !load_start && !rst;
    assign accept  = s_valid && s_ready;

`ifdef LOAD_CSUM_EN
    logic err_q, err_d;
    logic csum_clr;
    logic csum_match;

    percep_ld_csum u_csum (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (csum_clr),
        .en_i    (accept && ((state_q == LD_WGHT) || (state_q == LD_YDX))),
        .din_i   (s_data),
        .cmp_i   (s_data),
        .match_o (csum_match)
    );
`endif

    // Next-state, address counters and registered write strobes.
    always_comb begin
        state_d     = state_q;
        wght_cnt_d  = wght_cnt_q;
        ydx_cnt_d   = ydx_cnt_q;
        wr_wght_d   = 1'b0;
        wr_ydx_d    = 1'b0;
        addr_wght_d = addr_wght_q;
        addr_ydx_d  = addr_ydx_q;
        data_d      = data_q;
        done_d      = done_q;
`ifdef LOAD_CSUM_EN
        err_d       = err_q;
        csum_clr    = 1'b0;
`endif
        if (load_start) begin
            state_d    = LD_WGHT;
            wght_cnt_d = '0;
            ydx_cnt_d  = '0;
            done_d     = 1'b0;
`ifdef LOAD_CSUM_EN
            err_d      = 1'b0;
            csum_clr   = 1'b1;
`endif
        end else begin
            case (state_q)
                LD_WGHT: begin
                    if (accept) begin
                        wr_wght_d   = 1'b1;
                        addr_wght_d = wght_cnt_q;
                        data_d      = s_data;
                        if (wght_cnt_q == WGHT_LAST) begin
                            state_d = LD_YDX;
                        end else begin
                            wght_cnt_d = wght_cnt_q + MEM_ADDR_WGHT'(1);
                        end
                    end
                end
                LD_YDX: begin
                    if (accept) begin
                        wr_ydx_d   = 1'b1;
                        addr_ydx_d = ydx_cnt_q;
                        data_d     = s_data;
                        if (ydx_cnt_q == YDX_LAST) begin
`ifdef LOAD_CSUM_EN
                            state_d = CHK;
`else
                            state_d = DONE;
`endif
                        end else begin
                            ydx_cnt_d = ydx_cnt_q + MEM_ADDR_YDX'(1);
                        end
                    end
                end
                CHK: begin
`ifdef LOAD_CSUM_EN
                    // Trailer is compared, never written.
                    if (accept) begin
                        state_d = DONE;
                        done_d  = csum_match;
                        err_d   = !csum_match;
                    end
`endif
                end
                DONE: begin
`ifndef LOAD_CSUM_EN
                    // One cycle after entry, so done trails the last write strobe.
                    done_d = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    // State and output registers; synchronous reset abandons any partial load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wght_cnt_q  <= '0;
            ydx_cnt_q   <= '0;
            wr_wght_q   <= 1'b0;
            wr_ydx_q    <= 1'b0;
            addr_wght_q <= '0;
            addr_ydx_q  <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wght_cnt_q  <= wght_cnt_d;
            ydx_cnt_q   <= ydx_cnt_d;
            wr_wght_q   <= wr_wght_d;
            wr_ydx_q    <= wr_ydx_d;
            addr_wght_q <= addr_wght_d;
            addr_ydx_q  <= addr_ydx_d;
            data_q      <= data_d;
            done_q      <= done_d;
        end
    end

`ifdef LOAD_CSUM_EN
    // Error flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign load_err = err_q;
`else
    assign load_err = 1'b0;
`endif

    assign mem_cs_wght = wr_wght_q;
    assign mem_we_wght = wr_wght_q;
    assign mem_oe_wght = 1'b0;
    assign d_addr_wght = addr_wght_q;
    assign mem_cs_ydx  = wr_ydx_q;
    assign mem_we_ydx  = wr_ydx_q;
    assign mem_oe_ydx  = 1'b0;
    assign d_addr_ydx  = addr_ydx_q;
    assign d_mem_in    = data_q;
    assign load_done   = done_q;

endmodule

// File: tb/tb_percep_mem_loader.sv
// Bench for percep_mem_loader: table of load scenarios plus a write scoreboard.
// Build with +define+LOAD_CSUM_EN to exercise the checksum trailer.
module tb_percep_mem_loader;
    import percep_pkg::*;

    localparam int NW = ATTR + YDX_WORDS;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     load_start = 1'b0;
    logic [MEM_WIDTH_YDX-1:0] s_data = '0;
    logic                     s_valid = 1'b0;
    logic                     s_ready;
    logic                     mem_cs_ydx, mem_we_ydx, mem_oe_ydx;
    logic [MEM_ADDR_YDX-1:0]  d_addr_ydx;
    logic                     mem_cs_wght, mem_we_wght, mem_oe_wght;
    logic [MEM_ADDR_WGHT-1:0] d_addr_wght;
    logic [MEM_WIDTH_YDX-1:0] d_mem_in;
    logic                     load_done, load_err;

    always #5 clk = ~clk;

    percep_mem_loader dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .mem_cs_ydx  (mem_cs_ydx),
        .mem_we_ydx  (mem_we_ydx),
        .mem_oe_ydx  (mem_oe_ydx),
        .d_addr_ydx  (d_addr_ydx),
        .mem_cs_wght (mem_cs_wght),
        .mem_we_wght (mem_we_wght),
        .mem_oe_wght (mem_oe_wght),
        .d_addr_wght (d_addr_wght),
        .d_mem_in    (d_mem_in),
        .load_done   (load_done),
        .load_err    (load_err)
    );

    typedef struct {
        bit                       is_wght;
        int                       addr;
        logic [MEM_WIDTH_YDX-1:0] data;
    } wr_t;

    typedef struct {
        int max_gap;
        int kind;      // 0 none, 1 rst mid-load, 2 load_start mid-load
        int at;        // words accepted before the interruption
        bit bad_csum;
        bit exp_done;
        bit exp_err;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[5];

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_wr = 0;
    int last_wr_cyc = -1;
    int done_rise_cyc = -1;
    logic prev_done = 1'b0;
    logic [MEM_WIDTH_YDX-1:0] wimg [ATTR];
    logic [MEM_WIDTH_YDX-1:0] yimg [128];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (mem_cs_wght || mem_we_wght || mem_cs_ydx || mem_we_ydx) begin
            n_wr++;
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_write: got write addr_w=%0d addr_y=%0d expected none", d_addr_wght, d_addr_ydx);
            end else begin
                e = exp_q.pop_front();
                check("wr_cs_wght", 32'(mem_cs_wght), 32'(e.is_wght));
                check("wr_we_wght", 32'(mem_we_wght), 32'(e.is_wght));
                check("wr_cs_ydx", 32'(mem_cs_ydx), 32'(!e.is_wght));
                check("wr_we_ydx", 32'(mem_we_ydx), 32'(!e.is_wght));
                check("wr_oe", 32'({mem_oe_wght, mem_oe_ydx}), 32'd0);
                if (e.is_wght) check("wr_addr_wght", 32'(d_addr_wght), e.addr);
                else           check("wr_addr_ydx", 32'(d_addr_ydx), e.addr);
                check("wr_data", 32'(d_mem_in), 32'(e.data));
            end
            if (mem_cs_wght && d_addr_wght < MEM_ADDR_WGHT'(ATTR)) wimg[d_addr_wght] = d_mem_in;
            if (mem_cs_ydx) yimg[d_addr_ydx] = d_mem_in;
        end
        if (load_done && !prev_done) done_rise_cyc = cyc;
        prev_done = load_done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        n_wr = 0;
        done_rise_cyc = -1;
    endtask

    task automatic send(input logic [MEM_WIDTH_YDX-1:0] d, input bit is_data, input int idx, output int acc_cyc);
        bit sent = 1'b0;
        wr_t e;
        acc_cyc = -1;
        s_valid = 1'b1;
        s_data  = d;
        for (int k = 0; k < 40 && !sent; k++) begin
            @(negedge clk);
            if (s_ready) begin
                if (is_data) begin
                    e.is_wght = (idx < ATTR);
                    e.addr    = (idx < ATTR) ? idx : idx - ATTR;
                    e.data    = d;
                    exp_q.push_back(e);
                end
                acc_cyc = cyc;
                sent = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        if (!sent) begin
            n_vec++;
            n_fail++;
            $display("FAIL send_timeout: word %0d not accepted within 40 cycles, expected accept", idx);
        end
    endtask

    task automatic run_vec(input int vi, input vec_t v);
        logic [MEM_WIDTH_YDX-1:0] w [NW];
        logic [MEM_WIDTH_YDX-1:0] sum = '0;
        int i = 0;
        bit intr = 1'b0;
        int acc;
        int trailer_cyc = -1;
        for (int j = 0; j < NW; j++) begin
            w[j] = MEM_WIDTH_YDX'($urandom);
            sum  = sum + w[j];
        end
        pulse_start();
        check("start_done_clr", 32'(load_done), 32'd0);
        while (i < NW) begin
            if (v.kind != 0 && !intr && i == v.at) begin
                intr = 1'b1;
                if (v.kind == 1) begin
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    check("midrst_outputs", 32'({s_ready, mem_cs_wght, mem_we_wght, mem_cs_ydx, mem_we_ydx, load_done, load_err}), 32'd0);
                    check("midrst_addr_data", 32'({d_addr_wght, d_addr_ydx, d_mem_in}), 32'd0);
                    tick();
                    check("idle_no_ready", 32'(s_ready), 32'd0);
                    pulse_start();
                end else begin
                    pulse_start();
                    check("restart_done_clr", 32'(load_done), 32'd0);
                end
                i = 0;
            end
            repeat ($urandom_range(0, v.max_gap)) tick();
            if (i == NW - 1) check("done_early", 32'(load_done), 32'd0);
            send(w[i], 1'b1, i, acc);
            i++;
        end
`ifdef LOAD_CSUM_EN
        send(sum + MEM_WIDTH_YDX'(v.bad_csum), 1'b0, NW, trailer_cyc);
`endif
        // Extra word held valid after the image is complete must never be taken.
        s_valid = 1'b1;
        s_data  = MEM_WIDTH_YDX'($urandom);
        repeat (4) begin
            @(negedge clk);
            check("ready_after_last", 32'(s_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        check("write_count", n_wr, NW);
        check("queue_empty", exp_q.size(), 0);
        check("load_done", 32'(load_done), 32'(v.exp_done));
        check("load_err", 32'(load_err), 32'(v.exp_err));
        if (v.exp_done) begin
`ifdef LOAD_CSUM_EN
            check("done_timing", done_rise_cyc, trailer_cyc + 1);
`else
            check("done_timing", done_rise_cyc, last_wr_cyc + 1);
`endif
        end
        for (int j = 0; j < ATTR; j++) check("img_wght", 32'(wimg[j]), 32'(w[j]));
        for (int j = 0; j < YDX_WORDS; j++) check("img_ydx", 32'(yimg[j]), 32'(w[ATTR + j]));
        if (vi < 0) $display("unused");
    endtask

    initial begin
        vecs[0] = '{max_gap: 0, kind: 0, at: 0,  bad_csum: 0, exp_done: 1, exp_err: 0};
        vecs[1] = '{max_gap: 3, kind: 0, at: 0,  bad_csum: 0, exp_done: 1, exp_err: 0};
        vecs[2] = '{max_gap: 0, kind: 1, at: 50, bad_csum: 0, exp_done: 1, exp_err: 0};
        vecs[3] = '{max_gap: 2, kind: 2, at: 30, bad_csum: 0, exp_done: 1, exp_err: 0};
`ifdef LOAD_CSUM_EN
        vecs[4] = '{max_gap: 1, kind: 0, at: 0,  bad_csum: 1, exp_done: 0, exp_err: 1};
`else
        vecs[4] = '{max_gap: 1, kind: 0, at: 0,  bad_csum: 1, exp_done: 1, exp_err: 0};
`endif

        repeat (3) tick();
        check("reset_outputs", 32'({s_ready, mem_cs_wght, mem_we_wght, mem_oe_wght, mem_cs_ydx, mem_we_ydx, mem_oe_ydx, load_done, load_err}), 32'd0);
        check("reset_addr_data", 32'({d_addr_wght, d_addr_ydx, d_mem_in}), 32'd0);

        // Reset must win over a simultaneous load_start.
        load_start = 1'b1;
        s_valid    = 1'b1;
        tick();
        load_start = 1'b0;
        rst        = 1'b0;
        check("rst_over_start", 32'(s_ready), 32'd0);
        tick();
        check("idle_stays", 32'({s_ready, mem_cs_wght, mem_cs_ydx}), 32'd0);
        s_valid = 1'b0;

        for (int vi = 0; vi < 5; vi++) run_vec(vi, vecs[vi]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
